// File: rtl/lot_occupancy.sv
// lot_occupancy: multi-lane parking-lot occupancy tracker.
//
// Each lane has an outer (c) and inner (d) beam. A per-lane FSM accepts only
// a complete four-phase crossing (10,11,01,00 = entry; 01,11,10,00 = exit),
// with back-up allowed, and emits a one-cycle enter/exit pulse. A shared
// counter nets all lane events each cycle and saturates at 0 and CAP.
//
// Optional build macro: LOT_SYNC_EN adds a 2-flop synchronizer on every c/d
// bit (2 extra cycles of latency). Leave it undefined for sync sensors.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   c      in   [LANES] outer beam blocked
//   d      in   [LANES] inner beam blocked
//   enter  out  [LANES] one-cycle validated entry pulse
//   exit   out  [LANES] one-cycle validated exit pulse
//   count  out  [CW]    current occupancy
//   full   out  count == CAP
//   empty  out  count == 0
//   ovf    out  one-cycle pulse: last update was clamped
module lot_occupancy #(
    parameter int LANES = 2,
    parameter int CAP   = 16,
    localparam int CW   = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] c,
    input  logic [LANES-1:0] d,
    output logic [LANES-1:0] enter,
    output logic [LANES-1:0] exit,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StE1    = 3'd1;
    localparam logic [2:0] StE2    = 3'd2;
    localparam logic [2:0] StE3    = 3'd3;
    localparam logic [2:0] StX1    = 3'd4;
    localparam logic [2:0] StX2    = 3'd5;
    localparam logic [2:0] StX3    = 3'd6;
    localparam logic [2:0] StAbort = 3'd7;

    logic [LANES-1:0] c_f;
    logic [LANES-1:0] d_f;

`ifdef LOT_SYNC_EN
    logic [LANES-1:0] c_s1, c_s2, d_s1, d_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_s1 <= '0;
            c_s2 <= '0;
            d_s1 <= '0;
            d_s2 <= '0;
        end else begin
            c_s1 <= c;
            c_s2 <= c_s1;
            d_s1 <= d;
            d_s2 <= d_s1;
        end
    end

    assign c_f = c_s2;
    assign d_f = d_s2;
`else
    assign c_f = c;
    assign d_f = d;
`endif

    logic [2:0]       state_q [LANES];
    logic [2:0]       state_d [LANES];
    logic [LANES-1:0] enter_d;
    logic [LANES-1:0] exit_d;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic [1:0] s;
            s          = {c_f[i], d_f[i]};
            state_d[i] = state_q[i];
            enter_d[i] = 1'b0;
            exit_d[i]  = 1'b0;
            case (state_q[i])
                StIdle: begin
                    case (s)
                        2'b10:   state_d[i] = StE1;
                        2'b01:   state_d[i] = StX1;
                        2'b11:   state_d[i] = StAbort;
                        default: state_d[i] = StIdle;
                    endcase
                end
                StE1: begin
                    case (s)
                        2'b10:   state_d[i] = StE1;
                        2'b11:   state_d[i] = StE2;
                        2'b00:   state_d[i] = StIdle;  // backed out, no report
                        default: state_d[i] = StAbort;
                    endcase
                end
                StE2: begin
                    case (s)
                        2'b11:   state_d[i] = StE2;
                        2'b01:   state_d[i] = StE3;
                        2'b10:   state_d[i] = StE1;
                        default: state_d[i] = StAbort;
                    endcase
                end
                StE3: begin
                    case (s)
                        2'b01:   state_d[i] = StE3;
                        2'b00: begin
                            state_d[i] = StIdle;
                            enter_d[i] = 1'b1;
                        end
                        2'b11:   state_d[i] = StE2;
                        default: state_d[i] = StAbort;
                    endcase
                end
                StX1: begin
                    case (s)
                        2'b01:   state_d[i] = StX1;
                        2'b11:   state_d[i] = StX2;
                        2'b00:   state_d[i] = StIdle;
                        default: state_d[i] = StAbort;
                    endcase
                end
                StX2: begin
                    case (s)
                        2'b11:   state_d[i] = StX2;
                        2'b10:   state_d[i] = StX3;
                        2'b01:   state_d[i] = StX1;
                        default: state_d[i] = StAbort;
                    endcase
                end
                StX3: begin
                    case (s)
                        2'b10:   state_d[i] = StX3;
                        2'b00: begin
                            state_d[i] = StIdle;
                            exit_d[i]  = 1'b1;
                        end
                        2'b11:   state_d[i] = StX2;
                        default: state_d[i] = StAbort;
                    endcase
                end
                default: begin
                    if (s == 2'b00) state_d[i] = StIdle;
                end
            endcase
        end
    end

    // Net all lane events in one signed sum, then clamp to [0, CAP].
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 ovf_d;
    logic [CW+3:0]        n_e;
    logic [CW+3:0]        n_x;
    logic signed [CW+3:0] sum;

    always_comb begin
        n_e = '0;
        n_x = '0;
        for (int i = 0; i < LANES; i++) begin
            n_e = n_e + {{(CW + 3){1'b0}}, enter_d[i]};
            n_x = n_x + {{(CW + 3){1'b0}}, exit_d[i]};
        end
        sum     = $signed({4'b0000, count_q}) + $signed(n_e) - $signed(n_x);
        count_d = sum[CW-1:0];
        ovf_d   = 1'b0;
        if (sum < 0) begin
            count_d = '0;
            ovf_d   = 1'b1;
        end else if (sum > $signed((CW + 4)'(CAP))) begin
            count_d = CW'(CAP);
            ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) state_q[i] <= StIdle;
            enter   <= '0;
            exit    <= '0;
            count_q <= '0;
            ovf     <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) state_q[i] <= state_d[i];
            enter   <= enter_d;
            exit    <= exit_d;
            count_q <= count_d;
            ovf     <= ovf_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(CAP));
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_lot_occupancy.sv
module tb_lot_occupancy;

    localparam int LANES = 2;
    localparam int CAP   = 2;
    localparam int CW    = $clog2(CAP + 1);
`ifdef LOT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [LANES-1:0] c;
    logic [LANES-1:0] d;
    logic [LANES-1:0] enter;
    logic [LANES-1:0] exit;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_en [LANES];
    int acc_ex [LANES];
    int acc_ovf;

    lot_occupancy #(.LANES(LANES), .CAP(CAP)) dut (
        .clk   (clk),
        .reset (reset),
        .c     (c),
        .d     (d),
        .enter (enter),
        .exit  (exit),
        .count (count),
        .full  (full),
        .empty (empty),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic clear_acc();
        for (int i = 0; i < LANES; i++) begin
            acc_en[i] = 0;
            acc_ex[i] = 0;
        end
        acc_ovf = 0;
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < LANES; i++) begin
            acc_en[i] += int'(enter[i]);
            acc_ex[i] += int'(exit[i]);
        end
        acc_ovf += int'(ovf);
    endtask

    task automatic drive(input logic [1:0] cv, input logic [1:0] dv, input int n);
        c = cv;
        d = dv;
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        c = '0;
        d = '0;
        repeat (3) step();
        reset = 1'b0;
        clear_acc();
        repeat (4) step();
        n_tests++;
        if (count !== 0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full);
        end
        n_tests++;
        if (acc_en[0] + acc_en[1] + acc_ex[0] + acc_ex[1] + acc_ovf != 0) begin
            n_fail++; $display("FAIL reset_pulses: got %0d pulses expected 0",
                               acc_en[0] + acc_en[1] + acc_ex[0] + acc_ex[1] + acc_ovf);
        end
    endtask

    task automatic test_entry();
        clear_acc();
        drive(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 3);
        drive(2'b00, 2'b01, 3);
        c = '0;
        d = '0;
        repeat (LAT - 1) step();
        n_tests++;
        if (count !== 0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL entry_pre: got count=%0d empty=%b expected 0 1", count, empty);
        end
        step();
        n_tests++;
        if (enter !== 2'b01 || count !== 1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL entry_pulse: got enter=%b count=%0d empty=%b expected 01 1 0",
                               enter, count, empty);
        end
        repeat (4) step();
        n_tests++;
        if (acc_en[0] != 1 || acc_en[1] != 0 || acc_ex[0] + acc_ex[1] != 0 || enter !== 2'b00) begin
            n_fail++; $display("FAIL entry_once: got en0=%0d en1=%0d ex=%0d expected 1 0 0",
                               acc_en[0], acc_en[1], acc_ex[0] + acc_ex[1]);
        end
    endtask

    task automatic run_exit_lane1();
        drive(2'b00, 2'b10, 3);
        drive(2'b10, 2'b10, 3);
        drive(2'b10, 2'b00, 3);
        c = '0;
        d = '0;
        repeat (LAT) step();
    endtask

    task automatic test_exit();
        clear_acc();
        run_exit_lane1();
        n_tests++;
        if (exit !== 2'b10 || count !== 0 || empty !== 1'b1 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL exit_pulse: got exit=%b count=%0d empty=%b ovf=%b expected 10 0 1 0",
                               exit, count, empty, ovf);
        end
        repeat (3) step();
        clear_acc();
        run_exit_lane1();
        n_tests++;
        if (exit !== 2'b10 || count !== 0 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL exit_underflow: got exit=%b count=%0d ovf=%b expected 10 0 1",
                               exit, count, ovf);
        end
        step();
        n_tests++;
        if (ovf !== 1'b0 || exit !== 2'b00) begin
            n_fail++; $display("FAIL exit_ovf_width: got ovf=%b exit=%b expected 0 00", ovf, exit);
        end
        repeat (3) step();
        n_tests++;
        if (acc_ex[1] != 1 || acc_ovf != 1 || acc_en[0] + acc_en[1] != 0) begin
            n_fail++; $display("FAIL exit_once: got ex1=%0d ovf=%0d en=%0d expected 1 1 0",
                               acc_ex[1], acc_ovf, acc_en[0] + acc_en[1]);
        end
    endtask

    task automatic test_abort();
        clear_acc();
        // Back-up to IDLE: 10,11,10,00
        drive(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 3);
        drive(2'b01, 2'b00, 3);
        drive(2'b00, 2'b00, 5);
        // Skipped phase: 10,01,00
        drive(2'b01, 2'b00, 3);
        drive(2'b00, 2'b01, 3);
        drive(2'b00, 2'b00, 5);
        // Both beams from idle: 11,00
        drive(2'b01, 2'b01, 3);
        drive(2'b00, 2'b00, 5);
        n_tests++;
        if (acc_en[0] + acc_en[1] + acc_ex[0] + acc_ex[1] + acc_ovf != 0) begin
            n_fail++; $display("FAIL abort_pulses: got %0d pulses expected 0",
                               acc_en[0] + acc_en[1] + acc_ex[0] + acc_ex[1] + acc_ovf);
        end
        n_tests++;
        if (count !== 0) begin
            n_fail++; $display("FAIL abort_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_back_to_back();
        clear_acc();
        // Entry with a back-up E3->E2, then a new entry after one clear cycle.
        drive(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 3);
        drive(2'b00, 2'b01, 3);
        drive(2'b01, 2'b01, 3);
        drive(2'b00, 2'b01, 3);
        drive(2'b00, 2'b00, 1);
        drive(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 3);
        drive(2'b00, 2'b01, 3);
        drive(2'b00, 2'b00, 6);
        n_tests++;
        if (acc_en[0] != 2 || acc_ovf != 0) begin
            n_fail++; $display("FAIL b2b_pulses: got en0=%0d ovf=%0d expected 2 0", acc_en[0], acc_ovf);
        end
        n_tests++;
        if (count !== 2 || full !== 1'b1 || empty !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count: got count=%0d full=%b empty=%b expected 2 1 0",
                               count, full, empty);
        end
        clear_acc();
        run_exit_lane1();
        repeat (3) step();
        n_tests++;
        if (count !== 1 || full !== 1'b0 || acc_ex[1] != 1) begin
            n_fail++; $display("FAIL b2b_exit: got count=%0d full=%b ex1=%0d expected 1 0 1",
                               count, full, acc_ex[1]);
        end
    endtask

    task automatic test_simultaneous();
        // Both lanes enter on the same edge from count 1: clamps at CAP.
        drive(2'b11, 2'b00, 3);
        drive(2'b11, 2'b11, 3);
        drive(2'b00, 2'b11, 3);
        c = '0;
        d = '0;
        repeat (LAT) step();
        n_tests++;
        if (enter !== 2'b11 || count !== 2 || full !== 1'b1 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL sim_clamp: got enter=%b count=%0d full=%b ovf=%b expected 11 2 1 1",
                               enter, count, full, ovf);
        end
        repeat (3) step();
        // Lane 0 enters while lane 1 exits: nets to zero.
        drive(2'b01, 2'b10, 3);
        drive(2'b11, 2'b11, 3);
        drive(2'b10, 2'b01, 3);
        c = '0;
        d = '0;
        repeat (LAT) step();
        n_tests++;
        if (enter !== 2'b01 || exit !== 2'b10 || count !== 2 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL sim_net: got enter=%b exit=%b count=%0d ovf=%b expected 01 10 2 0",
                               enter, exit, count, ovf);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        clear_acc();
        drive(2'b01, 2'b00, 3);
        drive(2'b01, 2'b01, 3);
        // Lane 0 in E2; reset while showing 01, which would otherwise reach E3.
        reset = 1'b1;
        drive(2'b00, 2'b01, 3);
        n_tests++;
        if (count !== 0 || enter !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_during: got count=%0d enter=%b expected 0 00", count, enter);
        end
        reset = 1'b0;
        drive(2'b00, 2'b01, 3);
        drive(2'b00, 2'b00, 6);
        n_tests++;
        if (acc_en[0] + acc_en[1] + acc_ex[0] + acc_ex[1] != 0) begin
            n_fail++; $display("FAIL rst_mid_pulses: got %0d pulses expected 0",
                               acc_en[0] + acc_en[1] + acc_ex[0] + acc_ex[1]);
        end
        n_tests++;
        if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_count: got count=%0d empty=%b full=%b expected 0 1 0",
                               count, empty, full);
        end
    endtask

    initial begin
        reset = 1'b1;
        c = '0;
        d = '0;
        clear_acc();
        test_reset();
        test_entry();
        test_exit();
        test_abort();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
